// File: rtl/i2c_slave_if.sv
// Bus and local-side signals of the I2C responder.
//   sclk, sda_in  : serial clock and resolved data line from the bus
//   sda_out       : open-drain data drive (1 = release, 0 = pull low)
//   rx_data/rx_valid : received byte and its one-clk strobe
//   tx_data/tx_load  : byte to transmit and the one-clk latch strobe
//   rw_out, busy, state : transfer direction, activity flag, debug FSM state
interface i2c_slave_if;
  logic       sclk;
  logic       sda_in;
  logic       sda_out;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       rw_out;
  logic       busy;
  logic [2:0] state;

  modport slave (
    input  sclk, sda_in, tx_data,
    output sda_out, rx_data, rx_valid, tx_load, rw_out, busy, state
  );

  modport master (
    output sclk, sda_in, tx_data,
    input  sda_out, rx_data, rx_valid, tx_load, rw_out, busy, state
  );
endinterface

// File: rtl/i2c_slave.sv
// I2C responder. Oversamples sclk/sda with clk, detects START/STOP, matches a
// 7-bit address, ACKs, then receives (master write) or transmits (master read)
// bytes MSB first.
//   clk  : system clock, >= 8x sclk
//   rst  : asynchronous active-low reset
//   bus  : i2c_slave_if.slave (serial pins plus byte-level local interface)
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h2D
) (
  input  logic        clk,
  input  logic        rst,
  i2c_slave_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    RX       = 3'd3,
    RX_ACK   = 3'd4,
    TX       = 3'd5,
    TX_ACK   = 3'd6,
    IGNORE   = 3'd7
  } state_t;

  // Two-flop synchronizers plus one history flop for edge detection.
  logic [1:0] scl_sync, sda_sync;
  logic       scl_q, sda_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], bus.sclk};
      sda_sync <= {sda_sync[0], bus.sda_in};
      scl_q    <= scl_sync[1];
      sda_q    <= sda_sync[1];
    end
  end

  logic scl, sda, scl_rise, scl_fall, start_c, stop_c;
  assign scl      = scl_sync[1];
  assign sda      = sda_sync[1];
  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;
  // sclk must be high on both sides of the sda transition to count as a bus event.
  assign start_c  = scl & scl_q & sda_q & ~sda;
  assign stop_c   = scl & scl_q & ~sda_q & sda;

  state_t     state_q, state_n;
  logic [2:0] cnt_q, cnt_n;
  logic [7:0] sh_q, sh_n;
  logic       sda_out_q, sda_out_n;
  logic [7:0] rx_data_q, rx_data_n;
  logic       rx_valid_q, rx_valid_n;
  logic       tx_load_q, tx_load_n;
  logic       rw_q, rw_n;
  logic       busy_q, busy_n;
  // ACK phase: 0 = waiting for the falling edge that starts the ACK bit,
  // 1 = ACK bit in progress (in TX_ACK: master has ACKed).
  logic       ph_q, ph_n;
  logic [7:0] shifted;

  assign shifted = {sh_q[6:0], sda};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      sda_out_q  <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      ph_q       <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      sh_q       <= sh_n;
      sda_out_q  <= sda_out_n;
      rx_data_q  <= rx_data_n;
      rx_valid_q <= rx_valid_n;
      tx_load_q  <= tx_load_n;
      rw_q       <= rw_n;
      busy_q     <= busy_n;
      ph_q       <= ph_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    sh_n       = sh_q;
    sda_out_n  = sda_out_q;
    rx_data_n  = rx_data_q;
    rx_valid_n = 1'b0;
    tx_load_n  = 1'b0;
    rw_n       = rw_q;
    busy_n     = busy_q;
    ph_n       = ph_q;

    if (stop_c) begin
      state_n   = IDLE;
      sda_out_n = 1'b1;
      busy_n    = 1'b0;
    end else if (start_c) begin
      state_n   = ADDR;
      sda_out_n = 1'b1;
      busy_n    = 1'b0;
      cnt_n     = '0;
    end else begin
      case (state_q)
        IDLE: sda_out_n = 1'b1;

        ADDR: if (scl_rise) begin
          sh_n  = shifted;
          cnt_n = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (shifted[7:1] == SLAVE_ADDR) begin
              rw_n    = shifted[0];
              busy_n  = 1'b1;
              ph_n    = 1'b0;
              state_n = ADDR_ACK;
            end else begin
              state_n = IGNORE;
            end
          end
        end

        ADDR_ACK: if (scl_fall) begin
          if (!ph_q) begin
            sda_out_n = 1'b0;
            ph_n      = 1'b1;
          end else if (!rw_q) begin
            sda_out_n = 1'b1;
            cnt_n     = '0;
            state_n   = RX;
          end else begin
            // First byte of a read: bit7 goes out on the ACK's trailing edge.
            sh_n      = bus.tx_data;
            sda_out_n = bus.tx_data[7];
            tx_load_n = 1'b1;
            cnt_n     = '0;
            state_n   = TX;
          end
        end

        RX: if (scl_rise) begin
          sh_n  = shifted;
          cnt_n = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rx_data_n  = shifted;
            rx_valid_n = 1'b1;
            ph_n       = 1'b0;
            state_n    = RX_ACK;
          end
        end

        RX_ACK: if (scl_fall) begin
          if (!ph_q) begin
            sda_out_n = 1'b0;
            ph_n      = 1'b1;
          end else begin
            sda_out_n = 1'b1;
            cnt_n     = '0;
            state_n   = RX;
          end
        end

        // cnt counts bits already on the line beyond bit7; the 8th falling
        // edge ends bit0 and hands the line to the master for its ACK.
        TX: if (scl_fall) begin
          if (cnt_q == 3'd7) begin
            sda_out_n = 1'b1;
            ph_n      = 1'b0;
            state_n   = TX_ACK;
          end else begin
            sda_out_n = sh_q[6];
            sh_n      = {sh_q[6:0], 1'b0};
            cnt_n     = cnt_q + 3'd1;
          end
        end

        TX_ACK: begin
          if (scl_rise) begin
            if (!sda) begin
              ph_n = 1'b1;
            end else begin
              busy_n  = 1'b0;
              state_n = IGNORE;
            end
          end else if (scl_fall && ph_q) begin
            sh_n      = bus.tx_data;
            sda_out_n = bus.tx_data[7];
            tx_load_n = 1'b1;
            cnt_n     = '0;
            state_n   = TX;
          end
        end

        IGNORE: sda_out_n = 1'b1;

        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.sda_out  = sda_out_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_load  = tx_load_q;
  assign bus.rw_out   = rw_q;
  assign bus.busy     = busy_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a timed I2C master drives the bus, the line is the
// wired-AND of master and slave drive, and expectations come from byte-level
// transaction rules (address match, ACK/NACK, byte sequences).
module tb_i2c_slave;
  localparam int Q = 100;  // quarter sclk period in ns (clk period 10 ns)

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  i2c_slave_if bus();

  logic [7:0] tx_bytes [16];
  int         tx_cnt  = 0;
  int         tx_base = 0;
  logic [3:0] tx_ptr;

  assign tx_ptr      = 4'(tx_cnt - tx_base);
  assign bus.sclk    = scl_m;
  assign bus.sda_in  = sda_m & bus.sda_out;
  assign bus.tx_data = tx_bytes[tx_ptr];

  i2c_slave #(.SLAVE_ADDR(7'h2D)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse monitor: logs received bytes, counts loads and slave pull-low cycles,
  // and flags overlapping or stretched strobes.
  int         rx_cnt  = 0;
  logic [7:0] rx_log [256];
  int         low_cnt = 0;
  int         overlap = 0;
  int         wide    = 0;
  logic       prev_rxv = 1'b0;
  logic       prev_txl = 1'b0;

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      rx_log[rx_cnt % 256] = bus.rx_data;
      rx_cnt++;
    end
    if (bus.tx_load) tx_cnt++;
    if (bus.sda_out === 1'b0) low_cnt++;
    if (bus.rx_valid && bus.tx_load) overlap++;
    if ((bus.rx_valid && prev_rxv) || (bus.tx_load && prev_txl)) wide++;
    prev_rxv = bus.rx_valid;
    prev_txl = bus.tx_load;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1);
  end

  // ---------------- master primitives ----------------
  task automatic clk_bit(input logic b, output logic s);
    sda_m = b;  #Q;
    scl_m = 1'b1; #Q;
    s = bus.sda_in; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic s;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, s);
      b = {b[6:0], s};
    end
    clk_bit(nack, s);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (bus.sda_out !== 1'b1) begin errors++; $display("FAIL reset_sda got %b exp 1", bus.sda_out); end
    checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", bus.rx_valid); end
    checks++; if (bus.tx_load !== 1'b0) begin errors++; $display("FAIL reset_tx_load got %b exp 0", bus.tx_load); end
    checks++; if (bus.rw_out !== 1'b0) begin errors++; $display("FAIL reset_rw got %b exp 0", bus.rw_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", bus.state); end
    rst = 1'b1;
    #(Q);
  endtask

  task automatic test_write;
    int rb = rx_cnt;
    logic a0, a1;
    i2c_start;
    send_byte(8'h5A, a0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL write_busy got %b exp 1", bus.busy); end
    send_byte(8'hA5, a1);
    i2c_stop; #(Q);
    checks++; if (a0 !== 1'b0) begin errors++; $display("FAIL write_addr_ack got %b exp 0", a0); end
    checks++; if (a1 !== 1'b0) begin errors++; $display("FAIL write_data_ack got %b exp 0", a1); end
    checks++; if (rx_cnt - rb != 1) begin errors++; $display("FAIL write_rx_pulses got %0d exp 1", rx_cnt - rb); end
    checks++; if (bus.rx_data !== 8'hA5) begin errors++; $display("FAIL write_rx_data got %h exp a5", bus.rx_data); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL write_busy_stop got %b exp 0", bus.busy); end
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL write_state got %0d exp 0", bus.state); end
  endtask

  task automatic test_mismatch;
    int rb = rx_cnt;
    int lb = low_cnt;
    logic a0, a1;
    i2c_start;
    send_byte(8'h5C, a0);
    checks++; if (bus.state !== 3'd7) begin errors++; $display("FAIL mism_state_addr got %0d exp 7", bus.state); end
    send_byte(8'hFF, a1);
    checks++; if (bus.state !== 3'd7) begin errors++; $display("FAIL mism_state_data got %0d exp 7", bus.state); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mism_busy got %b exp 0", bus.busy); end
    i2c_stop; #(Q);
    checks++; if (a0 !== 1'b1 || a1 !== 1'b1) begin errors++; $display("FAIL mism_acks got %b%b exp 11", a0, a1); end
    checks++; if (low_cnt != lb) begin errors++; $display("FAIL mism_sda_low got %0d exp 0", low_cnt - lb); end
    checks++; if (rx_cnt != rb) begin errors++; $display("FAIL mism_rx_pulses got %0d exp 0", rx_cnt - rb); end
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL mism_state_stop got %0d exp 0", bus.state); end
  endtask

  task automatic test_read;
    logic a;
    logic [7:0] b0, b1;
    tx_bytes[0] = 8'h3C;
    tx_bytes[1] = 8'h81;
    tx_base = tx_cnt;
    i2c_start;
    send_byte(8'h5B, a);
    checks++; if (bus.rw_out !== 1'b1) begin errors++; $display("FAIL read_rw got %b exp 1", bus.rw_out); end
    recv_byte(1'b0, b0);
    recv_byte(1'b1, b1);
    checks++; if (bus.state !== 3'd7) begin errors++; $display("FAIL read_state_nack got %0d exp 7", bus.state); end
    i2c_stop; #(Q);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL read_addr_ack got %b exp 0", a); end
    checks++; if (b0 !== 8'h3C) begin errors++; $display("FAIL read_byte0 got %h exp 3c", b0); end
    checks++; if (b1 !== 8'h81) begin errors++; $display("FAIL read_byte1 got %h exp 81", b1); end
    checks++; if (tx_cnt - tx_base != 2) begin errors++; $display("FAIL read_tx_loads got %0d exp 2", tx_cnt - tx_base); end
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL read_state_stop got %0d exp 0", bus.state); end
  endtask

  task automatic test_rstart;
    int rb = rx_cnt;
    logic a0, a1, s;
    logic [7:0] exp_b, b;
    exp_b = 8'($urandom);
    i2c_start;
    send_byte(8'h5A, a0);
    for (int i = 0; i < 4; i++) clk_bit(1'($urandom), s);
    i2c_start;
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL rstart_state got %0d exp 1", bus.state); end
    tx_bytes[0] = exp_b;
    tx_base = tx_cnt;
    send_byte(8'h5B, a1);
    checks++; if (bus.rw_out !== 1'b1) begin errors++; $display("FAIL rstart_rw got %b exp 1", bus.rw_out); end
    recv_byte(1'b1, b);
    i2c_stop; #(Q);
    checks++; if (a0 !== 1'b0 || a1 !== 1'b0) begin errors++; $display("FAIL rstart_acks got %b%b exp 00", a0, a1); end
    checks++; if (rx_cnt != rb) begin errors++; $display("FAIL rstart_rx_pulses got %0d exp 0", rx_cnt - rb); end
    checks++; if (b !== exp_b) begin errors++; $display("FAIL rstart_read got %h exp %h", b, exp_b); end
  endtask

  task automatic test_stop_mid;
    int rb = rx_cnt;
    logic a, s;
    logic [7:0] d;
    d = 8'($urandom);
    i2c_start;
    send_byte(8'h5A, a);
    send_byte(d, a);
    for (int i = 0; i < 5; i++) clk_bit(1'($urandom), s);
    i2c_stop; #(Q);
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL stopmid_state got %0d exp 0", bus.state); end
    checks++; if (bus.sda_out !== 1'b1) begin errors++; $display("FAIL stopmid_sda got %b exp 1", bus.sda_out); end
    checks++; if (bus.rx_data !== d) begin errors++; $display("FAIL stopmid_rx_data got %h exp %h", bus.rx_data, d); end
    checks++; if (rx_cnt - rb != 1) begin errors++; $display("FAIL stopmid_rx_pulses got %0d exp 1", rx_cnt - rb); end
  endtask

  task automatic test_reset_mid;
    logic s;
    logic [7:0] a = 8'h5A;
    i2c_start;
    for (int i = 7; i >= 0; i--) clk_bit(a[i], s);
    sda_m = 1'b1;
    checks++; if (bus.sda_out !== 1'b0 || bus.state !== 3'd2) begin errors++; $display("FAIL rstmid_pre got sda %b state %0d exp sda 0 state 2", bus.sda_out, bus.state); end
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    checks++; if (bus.sda_out !== 1'b1) begin errors++; $display("FAIL rstmid_sda got %b exp 1", bus.sda_out); end
    checks++; if (bus.state !== 3'd0 || bus.busy !== 1'b0 || bus.rw_out !== 1'b0) begin errors++; $display("FAIL rstmid_ctl got state %0d busy %b rw %b exp 0 0 0", bus.state, bus.busy, bus.rw_out); end
    checks++; if (bus.rx_data !== 8'h00 || bus.rx_valid !== 1'b0 || bus.tx_load !== 1'b0) begin errors++; $display("FAIL rstmid_data got %h %b %b exp 00 0 0", bus.rx_data, bus.rx_valid, bus.tx_load); end
    scl_m = 1'b1;
    #(Q);
    rst = 1'b1;
    #(Q);
  endtask

  task automatic test_random;
    for (int t = 0; t < 8; t++) begin
      logic       is_read = 1'($urandom);
      logic       match   = 1'($urandom);
      logic [6:0] addr    = 7'h2D;
      int         n       = $urandom_range(1, 3);
      int         rb      = rx_cnt;
      logic [7:0] d [3];
      logic       a;
      logic [7:0] b;
      if (!match) while (addr == 7'h2D) addr = 7'($urandom);
      for (int i = 0; i < 3; i++) d[i] = 8'($urandom);
      if (!is_read) begin
        i2c_start;
        send_byte({addr, 1'b0}, a);
        checks++; if (a !== !match) begin errors++; $display("FAIL rnd%0d_waddr_ack got %b exp %b", t, a, !match); end
        for (int i = 0; i < n; i++) begin
          send_byte(d[i], a);
          checks++; if (a !== !match) begin errors++; $display("FAIL rnd%0d_wdata_ack%0d got %b exp %b", t, i, a, !match); end
        end
        i2c_stop; #(Q);
        checks++; if (rx_cnt - rb != (match ? n : 0)) begin errors++; $display("FAIL rnd%0d_rx_count got %0d exp %0d", t, rx_cnt - rb, match ? n : 0); end
        if (match && rx_cnt - rb == n)
          for (int i = 0; i < n; i++) begin
            checks++; if (rx_log[(rb + i) % 256] !== d[i]) begin errors++; $display("FAIL rnd%0d_rx%0d got %h exp %h", t, i, rx_log[(rb + i) % 256], d[i]); end
          end
      end else begin
        for (int i = 0; i < 3; i++) tx_bytes[i] = d[i];
        tx_base = tx_cnt;
        i2c_start;
        send_byte({addr, 1'b1}, a);
        checks++; if (a !== !match) begin errors++; $display("FAIL rnd%0d_raddr_ack got %b exp %b", t, a, !match); end
        for (int i = 0; i < n; i++) begin
          recv_byte(i == n - 1, b);
          checks++; if (b !== (match ? d[i] : 8'hFF)) begin errors++; $display("FAIL rnd%0d_tx%0d got %h exp %h", t, i, b, match ? d[i] : 8'hFF); end
        end
        i2c_stop; #(Q);
        checks++; if (tx_cnt - tx_base != (match ? n : 0)) begin errors++; $display("FAIL rnd%0d_tx_loads got %0d exp %0d", t, tx_cnt - tx_base, match ? n : 0); end
      end
      checks++; if (bus.state !== 3'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_idle got state %0d busy %b exp 0 0", t, bus.state, bus.busy); end
    end
  endtask

  task automatic test_pulses;
    checks++; if (overlap != 0) begin errors++; $display("FAIL pulse_overlap got %0d exp 0", overlap); end
    checks++; if (wide != 0) begin errors++; $display("FAIL pulse_width got %0d exp 0", wide); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_mismatch;
    test_read;
    test_rstart;
    test_stop_mid;
    test_reset_mid;
    test_random;
    test_pulses;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
